// File: rtl/sram_arb_pkg.sv
// Shared definitions for the two-requester SRAM-like arbiter.
// Requester IDs are stored in the in-order source queue.
package sram_arb_pkg;

  typedef logic src_t;

  localparam src_t SRC_DATA = 1'b0;
  localparam src_t SRC_INST = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage

// File: rtl/sram_arb_idq.sv
// In-order source-ID queue: one bit per accepted, not-yet-answered request.
// A simultaneous push and pop leaves the count unchanged and advances both pointers.
module sram_arb_idq #(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  logic din,
  output logic head,
  output logic full,
  output logic empty
);

  localparam int AW = $clog2(DEPTH);

  logic          mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & (~empty | push);
  assign head    = mem[rd_ptr];

  // Storage carries no reset; only pointers and count do.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sram_arb2x1.sv
// Two-to-one arbiter sharing one SRAM-like downstream port between the CPU data
// (m0) and instruction (m1) ports, with in-order data_ok routing.
module sram_arb2x1
  import sram_arb_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int STARVE_LIM = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [1:0]  m0_size,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [1:0]  m1_size,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        s_req,
  output logic        s_wr,
  output logic [1:0]  s_size,
  output logic [3:0]  s_wstrb,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic        s_addr_ok,
  input  logic        s_data_ok,
  input  logic [31:0] s_rdata,
  output logic        err
);

  localparam int SW = $clog2(STARVE_LIM + 1);

  function automatic logic [SW-1:0] sat_inc(input logic [SW-1:0] v);
    return (v == SW'(STARVE_LIM)) ? v : v + 1'b1;
  endfunction

  logic          lock;
  src_t          lock_id;
  logic [SW-1:0] starve_cnt;
  logic          gnt_vld;
  src_t          gnt_id;
  logic          accept;
  logic          q_full;
  logic          q_empty;
  src_t          q_head;
  logic          q_pop;

  // A pending lock always wins so the in-flight request stays stable.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = SRC_DATA;
    if (lock) begin
      gnt_vld = 1'b1;
      gnt_id  = lock_id;
    end else if (!q_full) begin
      if (m1_req && (!m0_req || starve_cnt == SW'(STARVE_LIM))) begin
        gnt_vld = 1'b1;
        gnt_id  = SRC_INST;
      end else if (m0_req) begin
        gnt_vld = 1'b1;
      end
    end
  end

  assign s_req   = ~reset & gnt_vld & ((gnt_id == SRC_INST) ? m1_req : m0_req);
  assign s_wr    = (gnt_id == SRC_INST) ? m1_wr    : m0_wr;
  assign s_size  = (gnt_id == SRC_INST) ? m1_size  : m0_size;
  assign s_wstrb = (gnt_id == SRC_INST) ? m1_wstrb : m0_wstrb;
  assign s_addr  = (gnt_id == SRC_INST) ? m1_addr  : m0_addr;
  assign s_wdata = (gnt_id == SRC_INST) ? m1_wdata : m0_wdata;

  assign accept     = s_req & s_addr_ok;
  assign m0_addr_ok = accept & (gnt_id == SRC_DATA);
  assign m1_addr_ok = accept & (gnt_id == SRC_INST);

  assign q_pop      = s_data_ok & ~q_empty;
  assign m0_data_ok = ~reset & q_pop & (q_head == SRC_DATA);
  assign m1_data_ok = ~reset & q_pop & (q_head == SRC_INST);
  assign m0_rdata   = s_rdata;
  assign m1_rdata   = s_rdata;

  sram_arb_idq #(.DEPTH(DEPTH)) u_idq (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .pop   (q_pop),
    .din   (gnt_id),
    .head  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );

  // Lock holds the grant while a presented request waits for addr_ok.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lock       <= 1'b0;
      lock_id    <= SRC_DATA;
      starve_cnt <= '0;
      err        <= 1'b0;
    end else begin
      lock <= s_req & ~s_addr_ok;
      if (s_req) lock_id <= gnt_id;
      if (!m1_req || (accept && gnt_id == SRC_INST)) starve_cnt <= '0;
      else if (accept) starve_cnt <= sat_inc(starve_cnt);
      if (s_data_ok && q_empty) err <= 1'b1;
    end
  end

endmodule

// File: doc/sram_arb2x1.md
Name: sram_arb2x1

Overview:
- Shares one downstream SRAM-like request port between the CPU data port (m0) and instruction port (m1).
- Sits between sram_cpu and a single-port SRAM-like-to-AXI bridge.
- Tracks up to DEPTH outstanding accepted requests in an in-order source-ID queue, so each downstream data_ok goes back to the right requester.
- Data port has fixed priority, with a starvation guard for the instruction port.

Parameters:
- DEPTH, 4, max outstanding accepted-but-unanswered requests; power of 2, >=2.
- STARVE_LIM, 4, consecutive data grants allowed while m1_req is pending before inst is forced to win.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- m0_req/m0_wr  in  1/1  data requester: request, write
- m0_size  in  2  data transfer size
- m0_wstrb  in  4  data byte strobes
- m0_addr/m0_wdata  in  32/32  data address, write data
- m0_addr_ok/m0_data_ok  out  1/1  data handshakes
- m0_rdata  out  32  data read data
- m1_*  same set as m0_*  instruction requester
- s_req/s_wr  out  1/1  downstream request, write
- s_size  out  2  downstream size
- s_wstrb  out  4  downstream strobes
- s_addr/s_wdata  out  32/32  downstream address, write data
- s_addr_ok/s_data_ok  in  1/1  downstream handshakes
- s_rdata  in  32  downstream read data
- err  out  1  sticky: s_data_ok arrived with queue empty

Behaviour:
- Reset (async, active-high):
  - Queue empty; lock clear; starve_cnt=0; err=0.
  - While reset=1, s_req, m0_addr_ok, m1_addr_ok, m0_data_ok and m1_data_ok are forced 0.
- Grant (combinational, from registered state):
  - Locked: grant=lock_id.
  - Else if queue full: no grant, s_req=0.
  - Else if m1_req and (!m0_req or starve_cnt==STARVE_LIM): grant inst.
  - Else if m0_req: grant data.
  - Else no grant.
- Downstream drive:
  - s_req = granted requester's req.
  - s_wr/s_size/s_wstrb/s_addr/s_wdata are muxed from the granted requester; data side when no grant.
- addr_ok routing:
  - mX_addr_ok = s_addr_ok & s_req & (grant==X); the non-granted port sees 0.
  - Zero-cycle combinational path.
- Lock: keeps the request stable as the SRAM-like protocol requires.
  - At a clock edge with s_req=1 and s_addr_ok=0: lock=1, lock_id=grant.
  - Cleared at the edge where s_addr_ok=1.
  - While locked, a higher-priority request never preempts.
  - Requesters must hold req and payload until addr_ok.
- Handshake: accept = s_req & s_addr_ok.
- ID queue (DEPTH entries, 1-bit id: 0=data, 1=inst):
  - Push grant on accept; pop head on s_data_ok.
  - Push and pop in the same cycle: count unchanged, both pointers advance; legal even when full or empty-with-push.
  - Count width is clog2(DEPTH)+1; pointers wrap modulo DEPTH.
- data_ok routing:
  - mX_data_ok = s_data_ok & !empty & (head==X).
  - m0_rdata = m1_rdata = s_rdata (broadcast).
  - s_data_ok with queue empty: no requester strobed, err<=1 and held until reset.
- Ordering: downstream returns data_ok in acceptance order; the block does not reorder.
- Starvation counter:
  - On a data accept while m1_req=1: starve_cnt+1, saturating at STARVE_LIM.
  - On an inst accept, or any cycle with m1_req=0: starve_cnt<=0.
- Reset mid-transaction: queue and lock are discarded; any late s_data_ok after reset sets err.

Decomposition:
- Package sram_arb_pkg holds:
  - SRC_DATA=1'b0, SRC_INST=1'b1.
  - Size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2.
- Sub-module sram_arb_idq: parameterised 1-bit-wide synchronous FIFO.
  - Ports: push/pop/din/head/full/empty.
  - Simultaneous push/pop rule as above.
- Grant mux, lock and starve logic live in the top.

Test Plan:
- Both requesters assert reads same cycle, s_addr_ok=1 always, data_ok 2 cycles later -> data accepted first.
  - With m0_req held continuously, inst accepted on the 5th handshake (STARVE_LIM=4).
  - data_ok order is 0,0,0,0,1.
- m1 read at 0x1FC00000 granted, s_addr_ok low 3 cycles while m0_req rises -> s_addr stays 0x1FC00000 and only m1_addr_ok pulses; m0 accepted the next cycle.
- Four accepts with no data_ok (DEPTH=4) -> s_req=0 despite pending reqs.
  - In the cycle s_data_ok pulses, the queue is full and s_req=0, so no new accept occurs and count drops to 3.
  - The next request is accepted the following cycle; head id routing is correct.
- Queue at count=3, accept and s_data_ok in the same cycle -> count stays 3, correct id popped.
- s_data_ok pulse with empty queue -> both mX_data_ok=0; err=1 and stays 1.
- Assert reset with 2 outstanding and lock set -> all handshake outputs 0 immediately (async), queue empty.
  - After release, a fresh m0 write (wstrb=4'b0011, addr 0x80000004) passes through unchanged.
